// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic flow-controlled inter-stage register for the RV32I
// pipeline. It provides a valid/ready handshake, a synchronous squash (flush)
// and a saturating stall counter.
// Optional feature macro: PIPE_SKID_EN adds a second (skid) entry so that
// in_ready comes from a flop instead of combinationally from out_ready.
//
// Handshake: a word moves on a port only in a cycle where valid && ready are
// both high at the rising edge; a producer holds valid and data stable until
// that happens, and ready never depends on the same port's valid.
module pipe_stage_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Main entry (M): drives the downstream port directly.
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic accept;
    logic emit;

    assign emit        = m_valid_q && out_ready;
    assign accept      = in_valid && in_ready;
    assign out_valid   = m_valid_q;
    assign out_data    = m_data_q;
    assign stall_count = stall_q;

`ifdef PIPE_SKID_EN
    // Skid entry (S): catches the word accepted while M is stalled.
    logic             s_valid_q, s_valid_d;
    logic [WIDTH-1:0] s_data_q, s_data_d;
    logic             in_ready_q, in_ready_d;

    // Registered ready; flush still blocks acceptance in its own cycle.
    assign in_ready = in_ready_q && !flush;

    // Next-state for M/S: refill M from S first, otherwise take the input.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (emit && s_valid_q) begin
            // in_ready is low whenever S is full, so no accept here.
            m_valid_d = 1'b1;
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
        end else if (accept) begin
            if (!m_valid_q || emit) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
            end else begin
                s_valid_d = 1'b1;
                s_data_d  = in_data;
            end
        end else if (emit) begin
            m_valid_d = 1'b0;
        end
        in_ready_d = !s_valid_d;
    end

    // Skid entry and registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid_q  <= 1'b0;
            s_data_q   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            s_valid_q  <= s_valid_d;
            s_data_q   <= s_data_d;
            in_ready_q <= in_ready_d;
        end
    end
`else
    // Single entry: accept when empty or when the held word leaves this cycle.
    assign in_ready = !flush && (!m_valid_q || out_ready);

    // Next-state for M: a new word overrides the emit-clear.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (flush) begin
            m_valid_d = 1'b0;
        end else if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data;
        end else if (emit) begin
            m_valid_d = 1'b0;
        end
    end
`endif

    // Stall counter: counts cycles the downstream refused a valid word.
    always_comb begin
        stall_d = stall_q;
        if (m_valid_q && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // Main entry and stall counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            stall_q   <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            stall_q   <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scenarios plus randomized traffic for
// pipe_stage_reg, checked against a FIFO-style reference model.
// Works with or without PIPE_SKID_EN defined.
module tb_pipe_stage_reg;

    localparam int W = 32;

    // Clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;

    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [15:0]  stall_count;

    logic         in_ready2, out_valid2;
    logic [W-1:0] out_data2;
    logic [1:0]   stall_sat;

    pipe_stage_reg #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_count(stall_count)
    );

    pipe_stage_reg #(.WIDTH(W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .stall_count(stall_sat)
    );

    // Scoreboard / reference model
    logic [W-1:0] exp_q[$];       // words held by the stage, oldest first
    logic [W-1:0] emit_log[$];    // words observed leaving the DUT
    logic [W-1:0] last_front;
    int           exp_cnt;
    int           exp_sat;
    logic         last_acc;
    int           n_checks = 0;
    int           n_fail   = 0;

`ifdef PIPE_SKID_EN
    localparam int CAPACITY = 2;
`else
    localparam int CAPACITY = 1;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_front = '0;
        exp_cnt    = 0;
        exp_sat    = 0;
    endtask

    // Driver: called at a negedge; drives one cycle, checks, advances model.
    task automatic drive_cycle(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
        logic exp_rdy, exp_vld, acc, emt;
        logic [W-1:0] exp_dat;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_vld = (exp_q.size() > 0);
        exp_dat = exp_vld ? exp_q[0] : last_front;
        if (CAPACITY == 1) exp_rdy = !fl && (exp_q.size() == 0 || ordy);
        else               exp_rdy = !fl && (exp_q.size() < 2);
        check_eq("out_valid", out_valid, exp_vld);
        check_eq("out_data", out_data, exp_dat);
        check_eq("in_ready", in_ready, exp_rdy);
        check_eq("stall_count", stall_count, exp_cnt);
        check_eq("sat_out_valid", out_valid2, exp_vld);
        check_eq("sat_out_data", out_data2, exp_dat);
        check_eq("sat_in_ready", in_ready2, exp_rdy);
        check_eq("sat_stall_count", stall_sat, exp_sat);
        if (out_valid && ordy) emit_log.push_back(out_data);
        acc = iv && exp_rdy;
        emt = exp_vld && ordy;
        last_acc = acc;
        @(posedge clk);
        if (exp_vld && !ordy) begin
            if (exp_cnt < (1 << 16) - 1) exp_cnt++;
            if (exp_sat < (1 << 2) - 1)  exp_sat++;
        end
        if (fl) begin
            exp_q.delete();
        end else begin
            if (emt) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(d);
        end
        if (exp_q.size() > 0) last_front = exp_q[0];
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] seq;
        int           cyc;

        // Reset state
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_stall", stall_count, 0);
        check_eq("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset mid-cycle while a word is held and stalled
        drive_cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        check_eq("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_valid", out_valid, 0);
        check_eq("async_rst_data", out_data, 0);
        check_eq("async_rst_stall", stall_count, 0);
        check_eq("async_rst_in_ready", in_ready, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Streaming with no bubbles
        emit_log.delete();
        drive_cycle(1'b1, 32'h11, 1'b1, 1'b0);
        drive_cycle(1'b1, 32'h22, 1'b1, 1'b0);
        drive_cycle(1'b1, 32'h33, 1'b1, 1'b0);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        check_eq("stream_count", emit_log.size(), 3);
        if (emit_log.size() == 3) begin
            check_eq("stream_w0", emit_log[0], 32'h11);
            check_eq("stream_w1", emit_log[1], 32'h22);
            check_eq("stream_w2", emit_log[2], 32'h33);
        end

        // Stall for 5 cycles with 0xCD offered behind 0xAB
        drive_cycle(1'b1, 32'hAB, 1'b0, 1'b0);
        repeat (5) drive_cycle(1'b1, 32'hCD, 1'b0, 1'b0);
        check_eq("stall5_count", stall_count, 5);
        check_eq("stall5_sat", stall_sat, 3);
        check_eq("stall5_held", out_data, 32'hAB);
        emit_log.delete();
        repeat (3) drive_cycle(1'b0, '0, 1'b1, 1'b0);
`ifdef PIPE_SKID_EN
        check_eq("release_count", emit_log.size(), 2);
        if (emit_log.size() == 2) begin
            check_eq("release_w0", emit_log[0], 32'hAB);
            check_eq("release_w1", emit_log[1], 32'hCD);
        end
`else
        check_eq("release_count", emit_log.size(), 1);
        if (emit_log.size() == 1) check_eq("release_w0", emit_log[0], 32'hAB);
`endif

        // Flush colliding with an offered word
        drive_cycle(1'b1, 32'h55, 1'b1, 1'b0);
        emit_log.delete();
        drive_cycle(1'b1, 32'h66, 1'b1, 1'b1);
        check_eq("flush_valid", out_valid, 0);
        check_eq("flush_stall", stall_count, 5);
        repeat (3) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        check_eq("flush_emits", emit_log.size(), 1);
        if (emit_log.size() == 1) check_eq("flush_w0", emit_log[0], 32'h55);

        // Saturation of the 2-bit counter over a 6-cycle stall
        drive_cycle(1'b1, 32'h77, 1'b0, 1'b0);
        repeat (6) drive_cycle(1'b0, '0, 1'b0, 1'b0);
        check_eq("sat_hold", stall_sat, 3);
        check_eq("stall11", stall_count, 11);
        repeat (3) drive_cycle(1'b0, '0, 1'b1, 1'b0);

        // out_ready toggling every cycle with in_valid held high
        emit_log.delete();
        seq = 32'h1000;
        cyc = 0;
        while (emit_log.size() < 100 && cyc < 1000) begin
            drive_cycle(1'b1, seq, cyc[0], 1'b0);
            if (last_acc) seq = seq + 1;
            cyc++;
        end
        check_eq("toggle_done", (emit_log.size() >= 100), 1);
        for (int i = 0; i < 100 && i < emit_log.size(); i++) begin
            check_eq("toggle_order", emit_log[i], 32'h1000 + i);
        end
        repeat (4) drive_cycle(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), $urandom,
                        1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end
        check_eq("end_sat", stall_sat, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
